// File: rtl/arm_pkg.sv
// Shared ARM core definitions: widths, memory geometry, reset PC and the fetch entry layout.
package arm_pkg;
    localparam int PC_WIDTH     = 32;
    localparam int INSTR_WIDTH  = 32;
    localparam int INS_MEM_SIZE = 32;
    localparam int RESET_PC     = 0;

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/arm_fetch_queue.sv
// Two-entry circular prefetch FIFO with push/pop/flush; head reads as zero when empty.
module arm_fetch_queue
    import arm_pkg::*;
#(
    parameter type entry_t = fetch_entry_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  entry_t     wdata,
    output entry_t     head,
    output logic [1:0] count,
    output logic       valid
);
    entry_t entries [0:1];
    logic   wr_ptr;
    logic   rd_ptr;
    logic   do_pop;
    logic   do_push;

    assign valid   = (count != 2'd0);
    assign do_pop  = pop && valid;
    // A full queue can only accept a new entry when the head leaves in the same cycle.
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = valid ? entries[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            entries[0] <= '0;
            entries[1] <= '0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (do_push) begin
                entries[wr_ptr] <= wdata;
                wr_ptr          <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/arm_fetch_unit.sv
// Fetch front end: owns the PC, fills the prefetch queue, handles redirects and end-of-program halt.
module arm_fetch_unit
    import arm_pkg::*;
#(
    parameter int INS_MEM_SIZE = arm_pkg::INS_MEM_SIZE,
    parameter int PC_WIDTH     = arm_pkg::PC_WIDTH,
    parameter int RESET_PC     = arm_pkg::RESET_PC
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    output logic                if_valid,
    output logic [31:0]         if_instr,
    output logic [PC_WIDTH-1:0] if_pc,
    input  logic                dec_ready,
    input  logic                br_taken,
    input  logic [PC_WIDTH-1:0] br_target,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted
);
    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [31:0]         instr;
    } entry_t;

    localparam logic [PC_WIDTH-1:0] FETCH_LIMIT = PC_WIDTH'(INS_MEM_SIZE * 4);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK  = ~PC_WIDTH'(3);

    entry_t     wdata;
    entry_t     head;
    logic [1:0] count;
    logic       in_range;
    logic       pop;
    logic       fetch_en;

    assign in_range  = (pc < FETCH_LIMIT);
    // A redirect squashes the head, so decode's ready is ignored in that cycle.
    assign pop       = if_valid && dec_ready && !br_taken;
    assign fetch_en  = !br_taken && in_range && ((count < 2'd2) || pop);
    assign imem_addr = pc;
    assign wdata     = '{pc: pc, instr: imem_rdata};
    assign if_instr  = head.instr;
    assign if_pc     = head.pc;
    assign halted    = !in_range && (count == 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= PC_WIDTH'(RESET_PC);
        end else if (br_taken) begin
            pc <= br_target & ALIGN_MASK;
        end else if (fetch_en) begin
            pc <= pc + PC_WIDTH'(4);
        end
    end

    arm_fetch_queue #(
        .entry_t (entry_t)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (fetch_en),
        .pop   (pop),
        .flush (br_taken),
        .wdata (wdata),
        .head  (head),
        .count (count),
        .valid (if_valid)
    );
endmodule
